// File: rtl/tama_pkg.sv
// Shared definitions for the pet button front end: test FSM encoding and test codes.
package tama_pkg;

    typedef enum logic [2:0] {
        T_IDLE   = 3'd0,
        T_HOLD   = 3'd1,
        T_ARMED  = 3'd2,
        T_COUNT  = 3'd3,
        T_COMMIT = 3'd4
    } test_state_t;

    localparam logic [3:0] IDLE    = 4'd1;
    localparam logic [3:0] NEUTRAL = 4'd2;
    localparam logic [3:0] TIRED   = 4'd3;
    localparam logic [3:0] SLEEP   = 4'd4;
    localparam logic [3:0] HUNGRY  = 4'd5;
    localparam logic [3:0] SAD     = 4'd6;
    localparam logic [3:0] PLAYING = 4'd7;
    localparam logic [3:0] BORED   = 4'd8;
    localparam logic [3:0] DEATH   = 4'd9;

    localparam logic [3:0] MAX_TEST_CODE = 4'd9;

    function automatic logic [3:0] sat_inc(input logic [3:0] code);
        return (code >= MAX_TEST_CODE) ? MAX_TEST_CODE : code + 4'd1;
    endfunction

endpackage

// File: rtl/tama_button_ctrl_debounce.sv
// One button: 2-FF synchroniser, polarity normalisation, debouncer and registered press edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic          synced;
    logic [CW-1:0] cnt;

    assign synced = (ACTIVE_LOW != 0) ? ~sync_q2 : sync_q2;

    // Synchroniser resets to the released raw level so no false press follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= RAW_RELEASED;
            sync_q2 <= RAW_RELEASED;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            level_q <= level;
            press   <= level & ~level_q;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/tama_button_ctrl.sv
// Button front end: five debouncers, gated action pulses and the test-mode entry/count/commit FSM.
//
// state    | meaning
// T_IDLE   | normal operation, action pulses pass through
// T_HOLD   | test button held, timing the long press
// T_ARMED  | long press reached, waiting for its release
// T_COUNT  | counting short test presses, idle timer runs while released
// T_COMMIT | presenting the committed code for COMMIT_HOLD cycles
module tama_button_ctrl
    import tama_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_PRESS      = 250000000,
    parameter int COMMIT_TIMEOUT  = 100000000,
    parameter int COMMIT_HOLD     = 4,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sleep_raw,
    input  logic       btn_awake_raw,
    input  logic       btn_feed_raw,
    input  logic       btn_play_raw,
    input  logic       btn_test_raw,
    output logic       boton_sleep,
    output logic       boton_awake,
    output logic       boton_feed,
    output logic       boton_play,
    output logic       boton_test,
    output logic [3:0] bpulse_test
);

    localparam int TMAX = (LONG_PRESS > COMMIT_TIMEOUT) ? LONG_PRESS : COMMIT_TIMEOUT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int HW   = (COMMIT_HOLD > 1) ? $clog2(COMMIT_HOLD) : 1;
    localparam logic [TW-1:0] LONG_LAST    = TW'(LONG_PRESS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(COMMIT_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(COMMIT_HOLD - 1);

    logic [4:0]    raw_bus;
    logic [4:0]    press_bus;
    logic [3:0]    unused_level;
    logic          test_level;
    test_state_t   state;
    logic [TW-1:0] timer;
    logic [HW-1:0] hold_cnt;
    logic [3:0]    press_cnt;

    assign raw_bus = {btn_test_raw, btn_play_raw, btn_feed_raw, btn_awake_raw, btn_sleep_raw};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic lvl;
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_bus[i]),
            .level(lvl),
            .press(press_bus[i])
        );
        if (i == 4) begin : g_test
            assign test_level = lvl;
        end else begin : g_act
            assign unused_level[i] = lvl;
        end
    end

    assign boton_sleep = press_bus[0] & (state == T_IDLE);
    assign boton_awake = press_bus[1] & (state == T_IDLE);
    assign boton_feed  = press_bus[2] & (state == T_IDLE);
    assign boton_play  = press_bus[3] & (state == T_IDLE);

    // One timer serves both the long-press hold and the post-release idle timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= T_IDLE;
            timer       <= '0;
            hold_cnt    <= '0;
            press_cnt   <= 4'd0;
            boton_test  <= 1'b0;
            bpulse_test <= 4'd0;
        end else begin
            case (state)
                T_IDLE: begin
                    if (press_bus[4]) begin
                        state <= T_HOLD;
                        timer <= '0;
                    end
                end
                T_HOLD: begin
                    if (!test_level) begin
                        state <= T_IDLE;
                    end else if (timer == LONG_LAST) begin
                        state      <= T_ARMED;
                        boton_test <= 1'b1;
                        timer      <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                T_ARMED: begin
                    if (!test_level) begin
                        state     <= T_COUNT;
                        press_cnt <= 4'd0;
                        timer     <= '0;
                    end
                end
                T_COUNT: begin
                    if (press_bus[4]) begin
                        press_cnt <= sat_inc(press_cnt);
                        timer     <= '0;
                    end else if (test_level) begin
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer <= '0;
                        if (press_cnt != 4'd0) begin
                            state       <= T_COMMIT;
                            boton_test  <= 1'b0;
                            bpulse_test <= press_cnt;
                            hold_cnt    <= '0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                T_COMMIT: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= T_IDLE;
                        bpulse_test <= 4'd0;
                        press_cnt   <= 4'd0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tama_button_ctrl.sv
// Directed bench for tama_button_ctrl with short timing parameters.
module tb_tama_button_ctrl;
    import tama_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_sleep_raw = 1'b1;
    logic       btn_awake_raw = 1'b1;
    logic       btn_feed_raw  = 1'b1;
    logic       btn_play_raw  = 1'b1;
    logic       btn_test_raw  = 1'b1;
    logic       boton_sleep, boton_awake, boton_feed, boton_play, boton_test;
    logic [3:0] bpulse_test;

    int vectors = 0;
    int miscompares = 0;
    int n_sleep = 0, n_awake = 0, n_feed = 0, n_play = 0;
    logic bt_seen = 1'b0;
    logic bp_seen = 1'b0;

    tama_button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LONG_PRESS     (20),
        .COMMIT_TIMEOUT (16),
        .COMMIT_HOLD    (2),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_sleep_raw(btn_sleep_raw),
        .btn_awake_raw(btn_awake_raw),
        .btn_feed_raw (btn_feed_raw),
        .btn_play_raw (btn_play_raw),
        .btn_test_raw (btn_test_raw),
        .boton_sleep  (boton_sleep),
        .boton_awake  (boton_awake),
        .boton_feed   (boton_feed),
        .boton_play   (boton_play),
        .boton_test   (boton_test),
        .bpulse_test  (bpulse_test)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (boton_sleep) n_sleep++;
            if (boton_awake) n_awake++;
            if (boton_feed)  n_feed++;
            if (boton_play)  n_play++;
            if (boton_test)  bt_seen = 1'b1;
            if (bpulse_test != 4'd0) bp_seen = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed run still active, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_test(input int low, input int high);
        btn_test_raw = 1'b0;
        ticks(low);
        btn_test_raw = 1'b1;
        ticks(high);
    endtask

    task automatic enter_test(input string tag);
        press_test(25, 10);
        check({tag, "_boton_test"}, boton_test, 1);
        check({tag, "_state"}, dut.state, T_COUNT);
    endtask

    task automatic wait_commit(input string tag);
        int k;
        k = 0;
        while (bpulse_test == 4'd0 && k < 60) begin
            tick();
            k++;
        end
        check({tag, "_found"}, (k < 60), 1);
    endtask

    initial begin
        int s0, p0;

        // Reset state
        ticks(3);
        check("rst_outputs", {boton_sleep, boton_awake, boton_feed, boton_play, boton_test}, 0);
        check("rst_bpulse", bpulse_test, 0);
        check("rst_state", dut.state, T_IDLE);
        rst = 1'b0;
        ticks(5);

        // Feed press with bounce, pulse exactly 7 cycles after final settle
        for (int i = 0; i < 2; i++) begin
            btn_feed_raw = 1'b0; ticks(2);
            btn_feed_raw = 1'b1; ticks(2);
        end
        btn_feed_raw = 1'b0;
        ticks(6);
        check("feed_before", boton_feed, 0);
        tick();
        check("feed_pulse", boton_feed, 1);
        tick();
        check("feed_after", boton_feed, 0);
        btn_feed_raw = 1'b1;
        ticks(12);
        check("feed_count", n_feed, 1);

        // Short test press
        bt_seen = 1'b0; bp_seen = 1'b0;
        press_test(10, 20);
        check("short_bt", bt_seen, 0);
        check("short_bp", bp_seen, 0);
        check("short_state", dut.state, T_IDLE);

        // Simultaneous action presses in idle
        btn_sleep_raw = 1'b0; btn_play_raw = 1'b0;
        ticks(10);
        btn_sleep_raw = 1'b1; btn_play_raw = 1'b1;
        ticks(10);
        check("simul_sleep", n_sleep, 1);
        check("simul_play", n_play, 1);
        check("simul_awake", n_awake, 0);

        // Test entry and code 3
        enter_test("code3_enter");
        for (int i = 0; i < 3; i++) press_test(8, 8);
        check("code3_pre_bt", boton_test, 1);
        check("code3_pre_bp", bpulse_test, 0);
        wait_commit("code3");
        check("code3_val0", bpulse_test, 3);
        check("code3_bt0", boton_test, 0);
        tick();
        check("code3_val1", bpulse_test, 3);
        tick();
        check("code3_clear", bpulse_test, 0);
        check("code3_state", dut.state, T_IDLE);
        ticks(10);

        // Saturation at 9
        enter_test("sat_enter");
        for (int i = 0; i < 12; i++) press_test(8, 8);
        wait_commit("sat");
        check("sat_val0", bpulse_test, 9);
        tick();
        check("sat_val1", bpulse_test, 9);
        tick();
        check("sat_clear", bpulse_test, 0);
        ticks(10);

        // Gating and zero-count timeout in test mode
        enter_test("gate_enter");
        s0 = n_sleep; p0 = n_play;
        btn_sleep_raw = 1'b0; btn_play_raw = 1'b0;
        ticks(10);
        btn_sleep_raw = 1'b1; btn_play_raw = 1'b1;
        ticks(10);
        check("gate_sleep", n_sleep, s0);
        check("gate_play", n_play, p0);
        bp_seen = 1'b0;
        ticks(40);
        check("zero_bt", boton_test, 1);
        check("zero_bp_seen", bp_seen, 0);
        check("zero_state", dut.state, T_COUNT);

        // Reset mid-count
        press_test(8, 8);
        press_test(8, 4);
        check("midrst_pre_bt", boton_test, 1);
        rst = 1'b1;
        #1;
        check("midrst_bt", boton_test, 0);
        check("midrst_bp", bpulse_test, 0);
        check("midrst_state", dut.state, T_IDLE);
        tick();
        rst = 1'b0;
        ticks(5);
        s0 = n_feed;
        btn_feed_raw = 1'b0;
        ticks(6);
        check("post_feed_before", boton_feed, 0);
        tick();
        check("post_feed_pulse", boton_feed, 1);
        btn_feed_raw = 1'b1;
        ticks(12);
        check("post_feed_count", n_feed, s0 + 1);
        enter_test("post_enter");
        press_test(8, 8);
        wait_commit("post");
        check("post_code", bpulse_test, 1);
        ticks(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
